// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the captured request.
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus data-memory strobes, bundled for the load/store unit.
interface lsu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              MemRead;
   logic              MemWrite;
   logic [31:0]       MemAddr;
   logic [31:0]       MemWData;
   logic [31:0]       memout;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, memout,
      input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, MemAddr, MemWData
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, memout,
      output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, MemAddr, MemWData
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane extraction for loads and lane merge for sub-word stores, little-endian within a word.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] memout,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask;
   logic [31:0] rep;

   always_comb begin
      case (lane)
         2'd0:    b = memout[7:0];
         2'd1:    b = memout[15:8];
         2'd2:    b = memout[23:16];
         default: b = memout[31:24];
      endcase
      h = lane[1] ? memout[31:16] : memout[15:0];

      case (size)
         SIZE_BYTE: ld_data = {{24{sgn & b[7]}}, b};
         SIZE_HALF: ld_data = {{16{sgn & h[15]}}, h};
         default:   ld_data = memout;
      endcase

      // Replicate the store data into every lane, then keep only the target lane.
      case (size)
         SIZE_BYTE: begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            rep  = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            rep  = {2{wdata[15:0]}};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            rep  = wdata;
         end
      endcase
      st_word = (memout & ~mask) | (rep & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: range/alignment checks, lane extract on loads, read-modify-write for sub-word stores.
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles from acceptance to resp_valid.
// Backpressure: response held until resp_ready; req_ready only in IDLE, one access in flight.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 200,
   parameter int ADDR_W    = 32
) (
   input  logic clk,
   input  logic rst_n,
   lsu_if.slave bus
);
   lsu_state_t  state;
   req_t        cur;
   logic        req_rdy;
   logic        resp_vld;
   logic        resp_err;
   logic [31:0] resp_dat;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdat;
   logic        acc_err;
   logic [31:0] ld_data;
   logic [31:0] st_word;

   always_comb begin
      acc_err = 1'b0;
      if (bus.req_size == SIZE_ILL)
         acc_err = 1'b1;
      if (bus.req_size == SIZE_HALF && bus.req_addr[0])
         acc_err = 1'b1;
      if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00)
         acc_err = 1'b1;
      if ((bus.req_addr >> 2) >= ADDR_W'(MEM_WORDS))
         acc_err = 1'b1;
   end

   lsu_lane_align u_align (
      .lane    (cur.lane),
      .size    (cur.size),
      .sgn     (cur.sgn),
      .memout  (bus.memout),
      .wdata   (cur.wdata),
      .ld_data (ld_data),
      .st_word (st_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cur      <= '0;
         req_rdy  <= 1'b1;
         resp_vld <= 1'b0;
         resp_err <= 1'b0;
         resp_dat <= '0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_wdat <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  cur     <= '{write: bus.req_write, size: bus.req_size, sgn: bus.req_signed,
                               lane: bus.req_addr[1:0], wdata: bus.req_wdata};
                  req_rdy <= 1'b0;
                  if (acc_err) begin
                     state    <= ST_RESP;
                     resp_vld <= 1'b1;
                     resp_err <= 1'b1;
                     resp_dat <= '0;
                  end else if (bus.req_write && bus.req_size == SIZE_WORD) begin
                     state    <= ST_WRITE;
                     mem_wr   <= 1'b1;
                     mem_addr <= 32'(bus.req_addr >> 2);
                     mem_wdat <= bus.req_wdata;
                  end else begin
                     state    <= ST_READ;
                     mem_rd   <= 1'b1;
                     mem_addr <= 32'(bus.req_addr >> 2);
                  end
               end
            end
            ST_READ: begin
               mem_rd <= 1'b0;
               if (cur.write) begin
                  state    <= ST_WRITE;
                  mem_wr   <= 1'b1;
                  mem_wdat <= st_word;
               end else begin
                  state    <= ST_RESP;
                  resp_vld <= 1'b1;
                  resp_err <= 1'b0;
                  resp_dat <= ld_data;
               end
            end
            ST_WRITE: begin
               mem_wr   <= 1'b0;
               state    <= ST_RESP;
               resp_vld <= 1'b1;
               resp_err <= 1'b0;
               resp_dat <= '0;
            end
            ST_RESP: begin
               // req_ready returns only after the handshake edge, never alongside it.
               if (bus.resp_ready) begin
                  state    <= ST_IDLE;
                  resp_vld <= 1'b0;
                  resp_err <= 1'b0;
                  req_rdy  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_rdy;
   assign bus.resp_valid = resp_vld;
   assign bus.resp_err   = resp_err;
   assign bus.resp_rdata = resp_dat;
   assign bus.MemRead    = mem_rd;
   assign bus.MemWrite   = mem_wr;
   assign bus.MemAddr    = mem_addr;
   assign bus.MemWData   = mem_wdat;

endmodule
